// File: rtl/battle_front_pkg.sv
// Shared types and constants for the lane-game battle-front coprocessor.
package battle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam int unsigned LOC_W   = 9;
    localparam int unsigned TYPE_W  = 2;
    localparam int unsigned N_SLOTS = 16;

    localparam logic [TYPE_W-1:0] TYPE_EMPTY = 2'd0;

    localparam int unsigned FRIEND_OFS_DEF = 6;
    localparam int unsigned ENEMY_OFS_DEF  = 7;

    localparam logic [LOC_W-1:0] NO_FRIEND_DEF = '1;
    localparam logic [LOC_W-1:0] NO_ENEMY_DEF  = '0;

endpackage

// File: rtl/battle_front_accum.sv
// Running extreme (min or max) of live slot locations, one slot per enabled cycle.
module front_accum
    import battle_pkg::*;
#(
    parameter int unsigned LOC_W_P  = LOC_W,
    parameter bit          MAX_MODE = 1'b0
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic               valid,
    input  logic [LOC_W_P-1:0] loc,
    output logic [LOC_W_P-1:0] extremeNext,
    output logic               foundNext
);

    localparam logic [LOC_W_P-1:0] INIT = MAX_MODE ? {LOC_W_P{1'b0}} : {LOC_W_P{1'b1}};

    logic [LOC_W_P-1:0] extreme;
    logic               found;
    logic               better;

    // Next values are exported so the last slot can be folded in without an extra cycle.
    always_comb begin
        better      = MAX_MODE ? (loc >= extreme) : (loc <= extreme);
        extremeNext = extreme;
        foundNext   = found;
        if (valid && better) begin
            extremeNext = loc;
            foundNext   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            extreme <= '0;
            found   <= 1'b0;
        end else if (clear) begin
            extreme <= INIT;
            found   <= 1'b0;
        end else if (enable) begin
            extreme <= extremeNext;
            found   <= foundNext;
        end
    end

endmodule

// File: rtl/battle_front.sv
// Battle-front coprocessor: scans 16 friendly and 16 enemy slots, reports the two fronts.
module battle_front
    import battle_pkg::*;
#(
    parameter int unsigned      FRIEND_OFS = FRIEND_OFS_DEF,
    parameter int unsigned      ENEMY_OFS  = ENEMY_OFS_DEF,
    parameter logic [LOC_W-1:0] NO_FRIEND  = NO_FRIEND_DEF,
    parameter logic [LOC_W-1:0] NO_ENEMY   = NO_ENEMY_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    input  logic              Ack,
    input  logic [LOC_W-1:0]  unitLoc0,  unitLoc1,  unitLoc2,  unitLoc3,
    input  logic [LOC_W-1:0]  unitLoc4,  unitLoc5,  unitLoc6,  unitLoc7,
    input  logic [LOC_W-1:0]  unitLoc8,  unitLoc9,  unitLoc10, unitLoc11,
    input  logic [LOC_W-1:0]  unitLoc12, unitLoc13, unitLoc14, unitLoc15,
    input  logic [TYPE_W-1:0] unitType0,  unitType1,  unitType2,  unitType3,
    input  logic [TYPE_W-1:0] unitType4,  unitType5,  unitType6,  unitType7,
    input  logic [TYPE_W-1:0] unitType8,  unitType9,  unitType10, unitType11,
    input  logic [TYPE_W-1:0] unitType12, unitType13, unitType14, unitType15,
    input  logic [LOC_W-1:0]  enemyLoc0,  enemyLoc1,  enemyLoc2,  enemyLoc3,
    input  logic [LOC_W-1:0]  enemyLoc4,  enemyLoc5,  enemyLoc6,  enemyLoc7,
    input  logic [LOC_W-1:0]  enemyLoc8,  enemyLoc9,  enemyLoc10, enemyLoc11,
    input  logic [LOC_W-1:0]  enemyLoc12, enemyLoc13, enemyLoc14, enemyLoc15,
    input  logic [TYPE_W-1:0] enemyType0,  enemyType1,  enemyType2,  enemyType3,
    input  logic [TYPE_W-1:0] enemyType4,  enemyType5,  enemyType6,  enemyType7,
    input  logic [TYPE_W-1:0] enemyType8,  enemyType9,  enemyType10, enemyType11,
    input  logic [TYPE_W-1:0] enemyType12, enemyType13, enemyType14, enemyType15,
    output logic [LOC_W-1:0]  friendlyFront,
    output logic [LOC_W-1:0]  enemyFront,
    output logic              Done
);

    localparam int unsigned      IDX_W    = $clog2(N_SLOTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLOTS - 1);
    localparam logic [LOC_W:0]   LOC_MAX  = {1'b0, {LOC_W{1'b1}}};

    logic [LOC_W-1:0]  uLoc [N_SLOTS];
    logic [TYPE_W-1:0] uTyp [N_SLOTS];
    logic [LOC_W-1:0]  eLoc [N_SLOTS];
    logic [TYPE_W-1:0] eTyp [N_SLOTS];

    assign uLoc = '{unitLoc0, unitLoc1, unitLoc2, unitLoc3, unitLoc4, unitLoc5, unitLoc6, unitLoc7,
                    unitLoc8, unitLoc9, unitLoc10, unitLoc11, unitLoc12, unitLoc13, unitLoc14, unitLoc15};
    assign uTyp = '{unitType0, unitType1, unitType2, unitType3, unitType4, unitType5, unitType6, unitType7,
                    unitType8, unitType9, unitType10, unitType11, unitType12, unitType13, unitType14, unitType15};
    assign eLoc = '{enemyLoc0, enemyLoc1, enemyLoc2, enemyLoc3, enemyLoc4, enemyLoc5, enemyLoc6, enemyLoc7,
                    enemyLoc8, enemyLoc9, enemyLoc10, enemyLoc11, enemyLoc12, enemyLoc13, enemyLoc14, enemyLoc15};
    assign eTyp = '{enemyType0, enemyType1, enemyType2, enemyType3, enemyType4, enemyType5, enemyType6, enemyType7,
                    enemyType8, enemyType9, enemyType10, enemyType11, enemyType12, enemyType13, enemyType14, enemyType15};

    state_t           state, nextState;
    logic [IDX_W-1:0] idx;
    logic             loadAcc, scanEn, lastSlot;

    logic [LOC_W-1:0] fMinNext, eMaxNext;
    logic             fFoundNext, eFoundNext;
    logic [LOC_W:0]   fWide, eWide;
    logic [LOC_W-1:0] friendCalc, enemyCalc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        loadAcc   = 1'b0;
        scanEn    = 1'b0;
        lastSlot  = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    nextState = SCAN;
                    loadAcc   = 1'b1;
                end
            end
            SCAN: begin
                scanEn = 1'b1;
                if (idx == LAST_IDX) begin
                    lastSlot  = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                if (Ack) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        idx <= '0;
        else if (loadAcc) idx <= '0;
        else if (scanEn)  idx <= idx + 1'b1;
    end

    front_accum #(.LOC_W_P(LOC_W), .MAX_MODE(1'b0)) uFriendMin (
        .clk         (clk),
        .rst         (rst),
        .clear       (loadAcc),
        .enable      (scanEn),
        .valid       (uTyp[idx] != TYPE_EMPTY),
        .loc         (uLoc[idx]),
        .extremeNext (fMinNext),
        .foundNext   (fFoundNext)
    );

    front_accum #(.LOC_W_P(LOC_W), .MAX_MODE(1'b1)) uEnemyMax (
        .clk         (clk),
        .rst         (rst),
        .clear       (loadAcc),
        .enable      (scanEn),
        .valid       (eTyp[idx] != TYPE_EMPTY),
        .loc         (eLoc[idx]),
        .extremeNext (eMaxNext),
        .foundNext   (eFoundNext)
    );

    // One extra bit of headroom so offsets saturate at the lane ends instead of wrapping.
    always_comb begin
        fWide = {1'b0, fMinNext};
        eWide = {1'b0, eMaxNext} + (LOC_W+1)'(ENEMY_OFS);
        if (!fFoundNext)                          friendCalc = NO_FRIEND;
        else if (fWide < (LOC_W+1)'(FRIEND_OFS)) friendCalc = '0;
        else                                      friendCalc = LOC_W'(fWide - (LOC_W+1)'(FRIEND_OFS));
        if (!eFoundNext)          enemyCalc = NO_ENEMY;
        else if (eWide > LOC_MAX) enemyCalc = '1;
        else                      enemyCalc = LOC_W'(eWide);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            friendlyFront <= '0;
            enemyFront    <= '0;
        end else if (lastSlot) begin
            friendlyFront <= friendCalc;
            enemyFront    <= enemyCalc;
        end
    end

    assign Done = (state == DONE);

endmodule

// File: tb/tb_battle_front.sv
// Scoreboard bench for battle_front: expected fronts queued at Start, checked at Done.
module tb_battle_front;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Start = 1'b0;
    logic       Ack = 1'b0;
    logic [8:0] uLoc [16];
    logic [1:0] uTyp [16];
    logic [8:0] eLoc [16];
    logic [1:0] eTyp [16];
    logic [8:0] friendlyFront, enemyFront;
    logic       Done;

    typedef struct packed {
        logic [8:0] f;
        logic [8:0] e;
    } exp_t;

    exp_t sbq[$];
    int   nChecks = 0;
    int   nFail = 0;

    always #5 clk = ~clk;

    battle_front dut (
        .clk(clk), .rst(rst), .Start(Start), .Ack(Ack),
        .unitLoc0(uLoc[0]), .unitLoc1(uLoc[1]), .unitLoc2(uLoc[2]), .unitLoc3(uLoc[3]),
        .unitLoc4(uLoc[4]), .unitLoc5(uLoc[5]), .unitLoc6(uLoc[6]), .unitLoc7(uLoc[7]),
        .unitLoc8(uLoc[8]), .unitLoc9(uLoc[9]), .unitLoc10(uLoc[10]), .unitLoc11(uLoc[11]),
        .unitLoc12(uLoc[12]), .unitLoc13(uLoc[13]), .unitLoc14(uLoc[14]), .unitLoc15(uLoc[15]),
        .unitType0(uTyp[0]), .unitType1(uTyp[1]), .unitType2(uTyp[2]), .unitType3(uTyp[3]),
        .unitType4(uTyp[4]), .unitType5(uTyp[5]), .unitType6(uTyp[6]), .unitType7(uTyp[7]),
        .unitType8(uTyp[8]), .unitType9(uTyp[9]), .unitType10(uTyp[10]), .unitType11(uTyp[11]),
        .unitType12(uTyp[12]), .unitType13(uTyp[13]), .unitType14(uTyp[14]), .unitType15(uTyp[15]),
        .enemyLoc0(eLoc[0]), .enemyLoc1(eLoc[1]), .enemyLoc2(eLoc[2]), .enemyLoc3(eLoc[3]),
        .enemyLoc4(eLoc[4]), .enemyLoc5(eLoc[5]), .enemyLoc6(eLoc[6]), .enemyLoc7(eLoc[7]),
        .enemyLoc8(eLoc[8]), .enemyLoc9(eLoc[9]), .enemyLoc10(eLoc[10]), .enemyLoc11(eLoc[11]),
        .enemyLoc12(eLoc[12]), .enemyLoc13(eLoc[13]), .enemyLoc14(eLoc[14]), .enemyLoc15(eLoc[15]),
        .enemyType0(eTyp[0]), .enemyType1(eTyp[1]), .enemyType2(eTyp[2]), .enemyType3(eTyp[3]),
        .enemyType4(eTyp[4]), .enemyType5(eTyp[5]), .enemyType6(eTyp[6]), .enemyType7(eTyp[7]),
        .enemyType8(eTyp[8]), .enemyType9(eTyp[9]), .enemyType10(eTyp[10]), .enemyType11(eTyp[11]),
        .enemyType12(eTyp[12]), .enemyType13(eTyp[13]), .enemyType14(eTyp[14]), .enemyType15(eTyp[15]),
        .friendlyFront(friendlyFront), .enemyFront(enemyFront), .Done(Done)
    );

    function automatic exp_t model();
        exp_t r;
        int   mn = 511;
        int   mx = 0;
        bit   fF = 1'b0;
        bit   fE = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (uTyp[i] != 2'd0 && int'(uLoc[i]) <= mn) begin mn = int'(uLoc[i]); fF = 1'b1; end
            if (eTyp[i] != 2'd0 && int'(eLoc[i]) >= mx) begin mx = int'(eLoc[i]); fE = 1'b1; end
        end
        r.f = !fF ? 9'd511 : (mn < 6 ? 9'd0 : 9'(mn - 6));
        r.e = !fE ? 9'd0 : (mx + 7 > 511 ? 9'd511 : 9'(mx + 7));
        return r;
    endfunction

    task automatic set_base();
        int base [16] = '{0, 32, 64, 128, 160, 192, 224, 256, 288, 320, 352, 384, 416, 448, 480, 511};
        for (int i = 0; i < 16; i++) begin
            uLoc[i] = 9'(base[i]);
            eLoc[i] = 9'(base[i]);
            uTyp[i] = 2'd0;
            eTyp[i] = 2'd0;
        end
    endtask

    // Called at posedge+1; the following edge samples Start.
    task automatic launch(input logic [8:0] ef, input logic [8:0] ee);
        exp_t x;
        x.f = ef;
        x.e = ee;
        sbq.push_back(x);
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    // 16 edges after the Start edge, i.e. Done after the 17th edge counting the Start edge.
    task automatic wait_done(input string name);
        int   n = 0;
        exp_t x;
        while (Done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        nChecks++;
        if (n !== 16) begin
            nFail++;
            $display("FAIL %s latency: got %0d edges, expected 16", name, n);
        end
        nChecks++;
        if (sbq.size() == 0) begin
            nFail++;
            $display("FAIL %s scoreboard: empty queue at Done, expected one entry", name);
        end else begin
            x = sbq.pop_front();
            if (friendlyFront !== x.f) begin
                nFail++;
                $display("FAIL %s friendlyFront: got %0d, expected %0d", name, friendlyFront, x.f);
            end
            nChecks++;
            if (enemyFront !== x.e) begin
                nFail++;
                $display("FAIL %s enemyFront: got %0d, expected %0d", name, enemyFront, x.e);
            end
        end
    endtask

    task automatic ack_done(input string name);
        Ack = 1'b1;
        @(posedge clk); #1;
        Ack = 1'b0;
        nChecks++;
        if (Done !== 1'b0) begin
            nFail++;
            $display("FAIL %s ack: Done got %b, expected 0", name, Done);
        end
    endtask

    task automatic test_reset();
        set_base();
        rst = 1'b0;
        #12;
        nChecks++;
        if (Done !== 1'b0 || friendlyFront !== 9'd0 || enemyFront !== 9'd0) begin
            nFail++;
            $display("FAIL reset: Done=%b ff=%0d ef=%0d, expected 0 0 0", Done, friendlyFront, enemyFront);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        set_base();
        launch(9'd511, 9'd0);
        wait_done("empty");
        ack_done("empty");
    endtask

    task automatic test_single();
        set_base();
        uTyp[14] = 2'd1;
        eTyp[1]  = 2'd1;
        launch(9'd474, 9'd39);
        wait_done("single");
        ack_done("single");
    endtask

    task automatic test_multi();
        set_base();
        uTyp[14] = 2'd1;
        eTyp[1]  = 2'd1;
        uTyp[2]  = 2'd2;
        eTyp[14] = 2'd2;
        launch(9'd58, 9'd487);
        wait_done("multi");
        ack_done("multi");
    endtask

    task automatic test_saturation();
        set_base();
        uLoc[5] = 9'd3;
        uTyp[5] = 2'd1;
        eLoc[9] = 9'd508;
        eTyp[9] = 2'd3;
        launch(9'd0, 9'd511);
        wait_done("saturation");
        ack_done("saturation");
    endtask

    task automatic test_handshake();
        bit held = 1'b1;
        set_base();
        uTyp[14] = 2'd1;
        eTyp[1]  = 2'd1;
        launch(9'd474, 9'd39);
        Start = 1'b1;
        wait_done("handshake_scan_start");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (Done !== 1'b1 || friendlyFront !== 9'd474 || enemyFront !== 9'd39) held = 1'b0;
        end
        nChecks++;
        if (!held) begin
            nFail++;
            $display("FAIL handshake hold: Done=%b ff=%0d ef=%0d, expected 1 474 39", Done, friendlyFront, enemyFront);
        end
        Ack = 1'b1;
        @(posedge clk); #1;
        Ack   = 1'b0;
        Start = 1'b0;
        nChecks++;
        if (Done !== 1'b0) begin
            nFail++;
            $display("FAIL handshake start+ack: Done got %b, expected 0", Done);
        end
        set_base();
        repeat (3) @(posedge clk);
        #1;
        nChecks++;
        if (Done !== 1'b0 || friendlyFront !== 9'd474 || enemyFront !== 9'd39) begin
            nFail++;
            $display("FAIL handshake persist: Done=%b ff=%0d ef=%0d, expected 0 474 39", Done, friendlyFront, enemyFront);
        end
        launch(9'd511, 9'd0);
        wait_done("handshake_rerun");
        ack_done("handshake_rerun");
    endtask

    task automatic test_reset_midscan();
        exp_t dropped;
        set_base();
        uTyp[14] = 2'd1;
        eTyp[1]  = 2'd1;
        launch(9'd474, 9'd39);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        dropped = sbq.pop_back();
        nChecks++;
        if (Done !== 1'b0 || friendlyFront !== 9'd0 || enemyFront !== 9'd0) begin
            nFail++;
            $display("FAIL midscan reset: Done=%b ff=%0d ef=%0d, expected 0 0 0 (dropped %0d/%0d)",
                     Done, friendlyFront, enemyFront, dropped.f, dropped.e);
        end
        @(negedge clk) rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        nChecks++;
        if (Done !== 1'b0 || friendlyFront !== 9'd0) begin
            nFail++;
            $display("FAIL midscan idle: Done=%b ff=%0d, expected 0 0", Done, friendlyFront);
        end
        launch(9'd474, 9'd39);
        wait_done("midscan_fresh");
        ack_done("midscan_fresh");
    endtask

    task automatic test_back_to_back();
        exp_t x;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++) begin
                uLoc[i] = 9'($urandom_range(511, 0));
                eLoc[i] = 9'($urandom_range(511, 0));
                uTyp[i] = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
                eTyp[i] = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
            end
            if (k == 5) begin
                uLoc[15] = 9'd0;   uTyp[15] = 2'd3;
                eLoc[15] = 9'd511; eTyp[15] = 2'd3;
            end
            x = model();
            launch(x.f, x.e);
            wait_done("back_to_back");
            ack_done("back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_multi();
        test_saturation();
        test_handshake();
        test_reset_midscan();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
